// File: rtl/newspaper_change_vendor_pkg.sv
// Shared coin encoding, state encoding and coin valuation for the newspaper vendor.
package newspaper_change_vendor_pkg;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_VEND      = 2'd1,
    ST_CHG_PULSE = 2'd2,
    ST_CHG_GAP   = 2'd3
  } state_t;

  // value in nickels; invalid and empty slots are worth nothing
  function automatic logic [1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_NICKEL: return 2'd1;
      COIN_DIME:   return 2'd2;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/newspaper_change_vendor_coin_pulse_emitter.sv
// Pays out a loaded amount as dime-first coin pulses, each followed by a one-cycle gap.
module coin_pulse_emitter
  import newspaper_change_vendor_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] amount,
  output logic [1:0]   coin_out,
  output logic         active,
  output logic         done
);

  state_t       st, st_nxt;
  logic [W-1:0] rem, rem_nxt, src;
  logic [1:0]   coin_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      st       <= ST_IDLE;
      rem      <= '0;
      coin_out <= COIN_NONE;
    end else begin
      st       <= st_nxt;
      rem      <= rem_nxt;
      coin_out <= coin_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:      if (load && amount != '0) st_nxt = ST_CHG_PULSE;
      ST_CHG_PULSE: st_nxt = ST_CHG_GAP;
      ST_CHG_GAP:   st_nxt = (rem != '0) ? ST_CHG_PULSE : ST_IDLE;
      default:      st_nxt = ST_IDLE;
    endcase
  end

  // coin is chosen for the pulse being entered, so coin_out is a plain register
  always_comb begin
    src      = (st == ST_IDLE) ? amount : rem;
    rem_nxt  = rem;
    coin_nxt = COIN_NONE;
    if (st_nxt == ST_CHG_PULSE) begin
      if (src >= W'(2)) begin
        coin_nxt = COIN_DIME;
        rem_nxt  = src - W'(2);
      end else begin
        coin_nxt = COIN_NICKEL;
        rem_nxt  = src - W'(1);
      end
    end
  end

  assign active = (st != ST_IDLE);
  assign done   = (st == ST_CHG_GAP) && (rem == '0);

endmodule

// File: rtl/newspaper_change_vendor.sv
// Newspaper vending core: credits coins, releases a paper at PRICE, returns change/refunds.
module newspaper_change_vendor
  import newspaper_change_vendor_pkg::*;
#(
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          coin_in,
  input  logic                coin_return,
  output logic                newspaper,
  output logic [1:0]          coin_out,
  output logic                busy,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  // top walks IDLE/VEND; the change states live inside the emitter
  state_t              st, st_nxt;
  logic [CREDIT_W-1:0] change, change_nxt, credit_nxt, total, load_amt;
  logic                idle, load, emit_active, emit_done;
  logic                newspaper_nxt, busy_nxt, reject_nxt;

  assign idle  = (st == ST_IDLE) && !emit_active;
  assign total = credit + CREDIT_W'(coin_value(coin_in));

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= ST_IDLE;
      change      <= '0;
      credit      <= '0;
      newspaper   <= 1'b0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      st          <= st_nxt;
      change      <= change_nxt;
      credit      <= credit_nxt;
      newspaper   <= newspaper_nxt;
      busy        <= busy_nxt;
      coin_reject <= reject_nxt;
    end
  end

  // vend wins over a refund requested on the same edge
  always_comb begin
    st_nxt     = st;
    change_nxt = change;
    credit_nxt = credit;
    case (st)
      ST_IDLE: if (idle) begin
        if (total >= PRICE_C) begin
          st_nxt     = ST_VEND;
          change_nxt = total - PRICE_C;
          credit_nxt = '0;
        end else if (coin_return && total != '0) begin
          credit_nxt = '0;
        end else begin
          credit_nxt = total;
        end
      end
      ST_VEND: begin
        st_nxt     = ST_IDLE;
        change_nxt = '0;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    load_amt = '0;
    if (st == ST_VEND && change != '0) begin
      load     = 1'b1;
      load_amt = change;
    end else if (idle && total < PRICE_C && coin_return && total != '0) begin
      load     = 1'b1;
      load_amt = total;
    end
    newspaper_nxt = (st_nxt == ST_VEND);
    busy_nxt      = newspaper_nxt || load || (emit_active && !emit_done);
    reject_nxt    = (coin_in == COIN_INVALID) || (coin_in != COIN_NONE && !idle);
  end

  coin_pulse_emitter #(.W(CREDIT_W)) u_emit (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .amount   (load_amt),
    .coin_out (coin_out),
    .active   (emit_active),
    .done     (emit_done)
  );

endmodule

// File: tb/tb_newspaper_change_vendor.sv
// Drives a PRICE=3 and a PRICE=5 vendor with shared stimulus against a scheduled-frame model.
module tb_newspaper_change_vendor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] coin_in = 2'b00;
  logic       coin_return = 1'b0;

  logic [1:0]      np, bz, rj;
  logic [1:0][1:0] co;
  logic [1:0][3:0] cr;
  logic [8:0]      obs [2];

  always #5 clock = ~clock;

  newspaper_change_vendor #(.PRICE(3), .CREDIT_W(4)) dut0 (
    .clock(clock), .reset(reset), .coin_in(coin_in), .coin_return(coin_return),
    .newspaper(np[0]), .coin_out(co[0]), .busy(bz[0]), .coin_reject(rj[0]), .credit(cr[0]));

  newspaper_change_vendor #(.PRICE(5), .CREDIT_W(4)) dut1 (
    .clock(clock), .reset(reset), .coin_in(coin_in), .coin_return(coin_return),
    .newspaper(np[1]), .coin_out(co[1]), .busy(bz[1]), .coin_reject(rj[1]), .credit(cr[1]));

  assign obs[0] = {np[0], co[0], bz[0], rj[0], cr[0]};
  assign obs[1] = {np[1], co[1], bz[1], rj[1], cr[1]};

  // stimulus word {reset, coin[1:0], coin_return}
  localparam logic [3:0] Z = 4'b0000, N = 4'b0010, D = 4'b0100, I = 4'b0110;
  localparam logic [3:0] R = 4'b0001, X = 4'b1000, NR = 4'b0011;

  int checks = 0;
  int errors = 0;

  // model: each machine's future output cycles as 4-bit frames {newspaper, coin[1:0], busy}
  int          price [2] = '{3, 5};
  int          mcred [2];
  logic [63:0] sched [2];
  int          slen  [2];
  logic [3:0]  mcur  [2];
  logic        mrej  [2];

  task automatic push(input int d, input logic [3:0] f);
    sched[d] = sched[d] | (64'(f) << (4 * slen[d]));
    slen[d]++;
  endtask

  task automatic model_edge(input logic rst, input logic [1:0] c, input logic ret);
    int v, total, chg;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mcred[d] = 0; sched[d] = '0; slen[d] = 0; mcur[d] = '0; mrej[d] = 1'b0;
      end else begin
        v = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
        mrej[d] = (c == 2'b11) || (c != 2'b00 && mcur[d][0]);
        if (!mcur[d][0]) begin
          total = mcred[d] + v;
          chg = -1;
          if (total >= price[d]) begin
            push(d, 4'b1001);
            chg = total - price[d];
          end else if (ret && total > 0) chg = total;
          if (chg >= 0) begin
            mcred[d] = 0;
            while (chg > 0) begin
              if (chg >= 2) begin push(d, 4'b0101); chg -= 2; end
              else begin push(d, 4'b0011); chg -= 1; end
              push(d, 4'b0001);
            end
          end else mcred[d] = total;
        end
        mcur[d]  = sched[d][3:0];
        sched[d] = sched[d] >> 4;
        if (slen[d] > 0) slen[d]--;
      end
    end
  endtask

  function automatic logic [8:0] expv(input int d);
    logic [31:0] c;
    c = mcred[d];
    return {mcur[d], mrej[d], c[3:0]};
  endfunction

  task automatic step(input logic [3:0] s);
    {reset, coin_in, coin_return} = s;
    @(posedge clock);
    model_edge(s[3], s[2:1], s[0]);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] s [2] = '{X, X};
    foreach (s[i]) begin
      step(s[i]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== 9'h000) begin
          errors++;
          $display("FAIL reset dut%0d cyc%0d got %b exp %b", d, i, obs[d], 9'h000);
        end
      end
    end
  endtask

  task automatic test_nickels();
    logic [3:0] s [7] = '{X, N, N, N, Z, Z, Z};
    foreach (s[i]) begin
      step(s[i]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL nickels dut%0d cyc%0d got %b exp %b", d, i, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_dime_dime();
    logic [3:0] s [7] = '{X, D, D, Z, Z, Z, Z};
    foreach (s[i]) begin
      step(s[i]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL dime_dime dut%0d cyc%0d got %b exp %b", d, i, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_exact();
    logic [3:0] s [5] = '{X, N, D, Z, Z};
    foreach (s[i]) begin
      step(s[i]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL exact dut%0d cyc%0d got %b exp %b", d, i, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_refund();
    logic [3:0] s [6] = '{X, D, R, Z, Z, Z};
    foreach (s[i]) begin
      step(s[i]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL refund dut%0d cyc%0d got %b exp %b", d, i, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_busy_reject();
    logic [3:0] s [10] = '{X, D, D, R, Z, N, Z, Z, Z, Z};
    foreach (s[i]) begin
      step(s[i]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL busy_reject dut%0d cyc%0d got %b exp %b", d, i, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [3:0] s [7] = '{X, N, I, I, R, N, Z};
    foreach (s[i]) begin
      step(s[i]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL invalid dut%0d cyc%0d got %b exp %b", d, i, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_vend_priority();
    logic [3:0] s [7] = '{X, N, N, NR, Z, Z, Z};
    foreach (s[i]) begin
      step(s[i]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL vend_priority dut%0d cyc%0d got %b exp %b", d, i, obs[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_reset_mid_change();
    logic [3:0] s [7] = '{X, D, R, X, Z, Z, Z};
    foreach (s[i]) begin
      step(s[i]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL reset_mid_change dut%0d cyc%0d got %b exp %b", d, i, obs[d], expv(d));
        end
        if (i >= 3) begin
          checks++;
          if (obs[d] !== 9'h000) begin
            errors++;
            $display("FAIL reset_mid_change_quiet dut%0d cyc%0d got %b exp %b", d, i, obs[d], 9'h000);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] s;
    int r;
    step(X);
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      s[2:1] = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      s[0]   = ($urandom_range(0, 5) == 0);
      s[3]   = ($urandom_range(0, 99) == 0);
      step(s);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d stim %b got %b exp %b", d, i, s, obs[d], expv(d));
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mcred[d] = 0; sched[d] = '0; slen[d] = 0; mcur[d] = '0; mrej[d] = 1'b0;
    end
    test_reset();
    test_nickels();
    test_dime_dime();
    test_exact();
    test_refund();
    test_busy_reject();
    test_invalid();
    test_vend_priority();
    test_reset_mid_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
